// File: rtl/ir_queue.sv
// Instruction prefetch queue: fetch strobes push memory words, advance strobes retire
// the head, and the current head is held in a registered instruction register.
module ir_queue #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 4,
  parameter int OPW       = 3,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ckFetch,
  input  logic                    ckNext,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        busData,
  output logic [WIDTH-1:0]        busIR,
  output logic [OPW-1:0]          opcode,
  output logic                    irValid,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULLCNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONECNT  = CW'(1);
  localparam logic [PW-1:0] LASTPTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr, wrPtr, rdNext, wrNext, wrPrev;
  logic             lastCkFetch, lastCkNext;
  logic             push, pop, isEmpty, isFull;
  logic             pushOk, popOk, overwriteHit, dropHit;
  logic [CW-1:0]    countNext;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == LASTPTR) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptrDec(input logic [PW-1:0] p);
    return (p == '0) ? LASTPTR : p - PW'(1);
  endfunction

  // A full queue still accepts a push when the head retires on the same edge.
  always_comb begin
    push         = ckFetch & ~lastCkFetch;
    pop          = ckNext & ~lastCkNext;
    isEmpty      = (count == '0);
    isFull       = (count == FULLCNT);
    popOk        = pop & ~isEmpty;
    pushOk       = push & (~isFull | popOk);
    overwriteHit = push & isFull & ~pop & OVERWRITE;
    dropHit      = push & isFull & ~pop & ~OVERWRITE;
    rdNext       = ptrInc(rdPtr);
    wrNext       = ptrInc(wrPtr);
    wrPrev       = ptrDec(wrPtr);
    countNext    = count;
    if (pushOk & ~popOk)
      countNext = count + ONECNT;
    else if (popOk & ~pushOk)
      countNext = count - ONECNT;
  end

  assign opcode = busIR[WIDTH-1 -: OPW];

  always_ff @(posedge CLK) begin
    if (!RESET && !flush) begin
      if (pushOk)
        mem[wrPtr] <= busData;
      else if (overwriteHit)
        mem[wrPrev] <= busData;
    end
  end

  // Strobe history is sampled unconditionally so a level held through reset or flush is not an edge.
  always_ff @(posedge CLK) begin
    lastCkFetch <= ckFetch;
    lastCkNext  <= ckNext;
    if (RESET) begin
      busIR     <= '0;
      irValid   <= 1'b0;
      full      <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else if (flush) begin
      irValid <= 1'b0;
      full    <= 1'b0;
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
    end else begin
      if (pushOk)
        wrPtr <= wrNext;
      if (popOk)
        rdPtr <= rdNext;
      if (dropHit)
        overflow <= 1'b1;
      if (pop & isEmpty)
        underflow <= 1'b1;
      // When the last entry retires with no replacement, busIR keeps the retired word.
      if (popOk) begin
        if (count == ONECNT) begin
          if (pushOk)
            busIR <= busData;
        end else begin
          busIR <= mem[rdNext];
        end
      end else if (pushOk & isEmpty) begin
        busIR <= busData;
      end else if (overwriteHit & (DEPTH == 1)) begin
        busIR <= busData;
      end
      count   <= countNext;
      full    <= (countNext == FULLCNT);
      irValid <= (countNext != '0);
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: a table of single-edge vectors plus hand-written
// multi-cycle sequences, with a word scoreboard for the queue drains.
module tb_ir_queue;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ckFetch = 1'b0;
  logic        ckNext = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] busData = '0;

  logic [11:0] busIR, busIROw, busIRD1;
  logic [2:0]  opcode, opcodeOw, opcodeD1;
  logic        irValid, irValidOw, irValidD1;
  logic        full, fullOw, fullD1;
  logic [2:0]  count, countOw;
  logic [0:0]  countD1;
  logic        overflow, overflowOw, overflowD1;
  logic        underflow, underflowOw, underflowD1;

  int checkCount = 0;
  int passCount = 0;
  logic [11:0] expQ[$];
  logic [11:0] expQOw[$];

  typedef struct {
    logic        fetch;
    logic        next;
    logic [11:0] data;
    logic [11:0] expIR;
    logic        expValid;
    logic [2:0]  expCount;
    logic        expFull;
    logic        expUnder;
  } vec_t;
  vec_t vecs[7];

  ir_queue #(.WIDTH(12), .DEPTH(4), .OPW(3), .OVERWRITE(1'b0)) dut (
    .CLK(CLK), .RESET(RESET), .ckFetch(ckFetch), .ckNext(ckNext), .flush(flush),
    .busData(busData), .busIR(busIR), .opcode(opcode), .irValid(irValid), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow));

  ir_queue #(.WIDTH(12), .DEPTH(4), .OPW(3), .OVERWRITE(1'b1)) dutOw (
    .CLK(CLK), .RESET(RESET), .ckFetch(ckFetch), .ckNext(ckNext), .flush(flush),
    .busData(busData), .busIR(busIROw), .opcode(opcodeOw), .irValid(irValidOw), .full(fullOw),
    .count(countOw), .overflow(overflowOw), .underflow(underflowOw));

  ir_queue #(.WIDTH(12), .DEPTH(1), .OPW(3), .OVERWRITE(1'b1)) dutD1 (
    .CLK(CLK), .RESET(RESET), .ckFetch(ckFetch), .ckNext(ckNext), .flush(flush),
    .busData(busData), .busIR(busIRD1), .opcode(opcodeD1), .irValid(irValidD1), .full(fullD1),
    .count(countD1), .overflow(overflowD1), .underflow(underflowD1));

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0o, expected %0o", name, actual, expected);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic f, input logic n, input logic fl, input logic [11:0] d);
    @(negedge CLK);
    ckFetch = f;
    ckNext  = n;
    flush   = fl;
    busData = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic f, input logic n, input logic [11:0] d);
    applyStimulus(f, n, 1'b0, d);
    applyStimulus(1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic doReset();
    RESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);
    RESET = 1'b0;
    expQ.delete();
    expQOw.delete();
  endtask

  task automatic modelPush(input logic [11:0] d);
    if (expQ.size() < 4)
      expQ.push_back(d);
    if (expQOw.size() < 4)
      expQOw.push_back(d);
    else
      expQOw[3] = d;
  endtask

  task automatic drainAndCompare(input string tag, input int expectSeen, input int expectSeenOw);
    int seen = 0;
    int seenOw = 0;
    for (int i = 0; i < 8; i++) begin
      if (!irValid && !irValidOw)
        break;
      if (irValid) begin
        seen++;
        if (expQ.size() > 0)
          checkOutput($sformatf("%s head%0d", tag, i), busIR, expQ.pop_front());
        else
          checkOutput($sformatf("%s unexpected head", tag), irValid, 1'b0);
      end
      if (irValidOw) begin
        seenOw++;
        if (expQOw.size() > 0)
          checkOutput($sformatf("%s ow head%0d", tag, i), busIROw, expQOw.pop_front());
        else
          checkOutput($sformatf("%s ow unexpected head", tag), irValidOw, 1'b0);
      end
      pulse(1'b0, 1'b1, 12'o0);
    end
    checkOutput({tag, " heads seen"}, seen, expectSeen);
    checkOutput({tag, " ow heads seen"}, seenOw, expectSeenOw);
    checkOutput({tag, " drained valid"}, irValid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 12'o7402, 12'o7402, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 12'o1234, 12'o7402, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 12'o5600, 12'o7402, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 12'o0000, 12'o1234, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 12'o0000, 12'o5600, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 12'o0000, 12'o5600, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 12'o0000, 12'o5600, 1'b0, 3'd0, 1'b0, 1'b1};

    doReset();
    checkOutput("reset busIR", busIR, 12'o0);
    checkOutput("reset opcode", opcode, 3'd0);
    checkOutput("reset irValid", irValid, 1'b0);
    checkOutput("reset full", full, 1'b0);
    checkOutput("reset count", count, 3'd0);
    checkOutput("reset overflow", overflow, 1'b0);
    checkOutput("reset underflow", underflow, 1'b0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].fetch, vecs[i].next, 1'b0, vecs[i].data);
      checkOutput($sformatf("vec%0d busIR", i), busIR, vecs[i].expIR);
      checkOutput($sformatf("vec%0d opcode", i), opcode, vecs[i].expIR[11:9]);
      checkOutput($sformatf("vec%0d irValid", i), irValid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d count", i), count, vecs[i].expCount);
      checkOutput($sformatf("vec%0d full", i), full, vecs[i].expFull);
      checkOutput($sformatf("vec%0d underflow", i), underflow, vecs[i].expUnder);
      applyStimulus(1'b0, 1'b0, 1'b0, vecs[i].data);
    end

    // Held strobes: one push, then one pop, no matter how long the level lasts.
    doReset();
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, 12'(i + 1));
    checkOutput("held fetch count", count, 3'd1);
    checkOutput("held fetch busIR", busIR, 12'o1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 12'o0);
    checkOutput("held next count", count, 3'd0);
    checkOutput("held next irValid", irValid, 1'b0);
    checkOutput("held next underflow", underflow, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);

    // ckFetch already high when reset releases.
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      RESET   = (i < 2);
      ckFetch = 1'b1;
      busData = 12'o4321;
      @(posedge CLK);
      #1;
    end
    checkOutput("fetch through reset count", count, 3'd0);
    checkOutput("fetch through reset irValid", irValid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);

    // Five pushes into a four-entry queue, with and without overwrite.
    doReset();
    for (int i = 1; i <= 5; i++) begin
      pulse(1'b1, 1'b0, 12'(i));
      modelPush(12'(i));
    end
    checkOutput("ovf count", count, 3'd4);
    checkOutput("ovf full", full, 1'b1);
    checkOutput("ovf overflow", overflow, 1'b1);
    checkOutput("ow count", countOw, 3'd4);
    checkOutput("ow full", fullOw, 1'b1);
    checkOutput("ow overflow", overflowOw, 1'b0);
    drainAndCompare("ovf drain", 4, 4);

    // Full queue, push and pop on the same edge.
    doReset();
    for (int i = 1; i <= 4; i++) begin
      pulse(1'b1, 1'b0, 12'(i));
      modelPush(12'(i));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 12'o11);
    void'(expQ.pop_front());
    expQ.push_back(12'o11);
    void'(expQOw.pop_front());
    expQOw.push_back(12'o11);
    checkOutput("full both count", count, 3'd4);
    checkOutput("full both busIR", busIR, 12'o2);
    checkOutput("full both full", full, 1'b1);
    checkOutput("full both overflow", overflow, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);
    drainAndCompare("full both drain", 4, 4);

    // Empty queue, push and pop on the same edge.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 12'o3333);
    checkOutput("empty both count", count, 3'd1);
    checkOutput("empty both busIR", busIR, 12'o3333);
    checkOutput("empty both irValid", irValid, 1'b1);
    checkOutput("empty both underflow", underflow, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);

    // Flush with three entries and a concurrent push; sticky flags survive.
    doReset();
    pulse(1'b0, 1'b1, 12'o0);
    pulse(1'b1, 1'b0, 12'o1);
    pulse(1'b1, 1'b0, 12'o2);
    pulse(1'b1, 1'b0, 12'o3);
    checkOutput("pre flush count", count, 3'd3);
    applyStimulus(1'b1, 1'b0, 1'b1, 12'o7);
    checkOutput("flush count", count, 3'd0);
    checkOutput("flush irValid", irValid, 1'b0);
    checkOutput("flush busIR", busIR, 12'o1);
    checkOutput("flush full", full, 1'b0);
    checkOutput("flush underflow", underflow, 1'b1);
    checkOutput("flush overflow", overflow, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);
    pulse(1'b1, 1'b0, 12'o5);
    checkOutput("post flush busIR", busIR, 12'o5);
    checkOutput("post flush count", count, 3'd1);

    // Single-entry overwrite queue: the head follows every fetch.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 12'(11 * (i + 1)));
      checkOutput($sformatf("d1 busIR %0d", i), busIRD1, 12'(11 * (i + 1)));
      applyStimulus(1'b0, 1'b0, 1'b0, 12'o0);
    end
    checkOutput("d1 count", countD1, 1'b1);
    checkOutput("d1 full", fullD1, 1'b1);
    checkOutput("d1 overflow", overflowD1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
